code_seg_scan: RTL and testbench
================================

Name: code_seg_scan

Overview:
- Display-side decoder for the switch code-entry path. Takes the packed nibble code and entered-digit count produced by the switch encoder and drives a time-multiplexed 7-segment display.
- Latches a new code on a load strobe and applies it only at a frame boundary, so the display never tears.
- Blanks digits not yet entered and blinks a cursor on the next digit to be entered.

Parameters:
- Byte, 4, number of display digits; code width is 4*Byte bits.
- CLK_DIV, 50000, clock cycles per digit slot (must be >= 4).
- DEAD, 500, cycles at the start of each slot with all anodes off (anti-ghost); must be < CLK_DIV.
- BLINK_FRAMES, 64, full scan frames per cursor blink half-period.
- ACTIVE_LOW, 1, 1 = Seg and An driven active-low (common-anode board); 0 = active-high.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- Code  in  4*Byte  packed digits; digit i = Code[4i+3:4i]; digit 0 is rightmost.
- Code_Bit  in  3  number of entered digits; values above Byte are clamped to Byte.
- Code_Load  in  1  one-cycle strobe; capture Code/Code_Bit.
- Load_Ack  out  1  one-cycle pulse when the pending code becomes the displayed code.
- Seg  out  8  {dp,g,f,e,d,c,b,a}; dp is always off.
- An  out  Byte  digit enables; one-hot when active.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high, sampled on the CLK rising edge.
- Reset values: slot counter 0, digit index 0, frame counter 0, blink phase 0 (cursor on), pending flag 0, shadow Code 0, shadow Code_Bit 0, Load_Ack 0. An and Seg are all inactive.
- Reset mid-frame: aborts the scan immediately, discards any pending load, and displays nothing in the next cycle.
- Capture: on Code_Load, Code and clamped Code_Bit go into pending registers and the pending flag is set.
  - A further Code_Load while pending overwrites the pending registers (newest wins) and produces only one Load_Ack.
- Scan counters:
  - slot counter runs 0..CLK_DIV-1; on wrap, digit index advances 0..Byte-1 and then wraps to 0.
  - A frame ends when digit index wraps from Byte-1 to 0.
- Apply: in the cycle the frame ends, if pending=1, the shadow registers take the pending values, pending clears, and Load_Ack=1 in the next cycle.
  - Load strobe coincident with the frame-end cycle: the strobe's data is captured into pending and applied at the following frame end (not the current one).
- Blink: frame counter counts frames 0..BLINK_FRAMES-1. At the end of the last frame it wraps and toggles blink phase.
- Digit content for digit index i, given shadow count n:
  - i < n: hex glyph of nibble i (0-9, A, b, C, d, E, F; standard segments).
  - i == n and n < Byte: cursor = segment d only when blink phase = 0, blank when phase = 1.
  - i > n, or the cursor digit when n == Byte: blank.
- Output timing:
  - An[i] is active only while slot counter >= DEAD for digit index i; all anodes are inactive during the dead time.
  - Seg is registered; it changes in the cycle the digit index changes, i.e. during dead time.
  - An and Seg are registered outputs: one-cycle latency from the counters.
- Polarity: apply ACTIVE_LOW inversion at the final output register only.

Decomposition:
- Shared package/header: hex-to-7seg glyph constants (16 entries, active-high), SEG_BLANK, SEG_CURSOR (8'h08).
- One sub-module, seg7_hex_decode: combinational nibble -> 8-bit active-high glyph.
- Counters, pending/apply logic, and blink logic stay in the top module.

Test Plan:
- Reset: RESET high 3 cycles, Byte=4, ACTIVE_LOW=1 -> An=4'hF and Seg=8'hFF throughout; Load_Ack=0.
- Basic load, with CLK_DIV=8, DEAD=2, BLINK_FRAMES=2: Code=16'h12A7, Code_Bit=4, Code_Load pulse -> Load_Ack exactly once at the next frame end. Digits 0..3 then show glyphs 7, A, 2, 1 with An[i]=0 only for slot cycles 2..7 of digit i.
- Partial entry and cursor: Code=16'h0035, Code_Bit=2 -> digits 0 and 1 show 5 and 3; digit 2 shows Seg=~8'h08 in frames 0-1 and 8'hFF in frames 2-3; digit 3 shows 8'hFF.
- Clamp and overwrite: Code_Bit=7, then a second Code_Load 3 cycles later with Code=16'hFFFF before the frame end -> single Load_Ack; all 4 digits show F; no cursor.
- Frame-end coincidence: Code_Load asserted in the frame-end cycle -> the old code is still displayed for one full frame; Load_Ack at the following frame end.
- Reset mid-operation: RESET asserted at digit index 2 with a load pending -> outputs inactive the next cycle. After release, the scan restarts at digit 0 with an empty display (cursor on digit 0) and no Load_Ack.

Source files
------------

// File: rtl/code_seg_scan_pkg.sv
// Shared definitions for the code-entry display scanner: active-high
// 7-segment glyphs and the classification of what a digit slot shows.
package code_seg_scan_pkg;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high; dp never lit.
  localparam logic [7:0] SEG_BLANK  = 8'h00;
  localparam logic [7:0] SEG_CURSOR = 8'h08;

  // Hex glyphs indexed by nibble value: 0-9, A, b, C, d, E, F.
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  // What the currently scanned digit position displays.
  typedef enum logic [1:0] {
    DIG_BLANK  = 2'd0,
    DIG_GLYPH  = 2'd1,
    DIG_CURSOR = 2'd2
  } dig_kind_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment glyph lookup.
module seg7_hex_decode
  import code_seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] glyph
);

  // Table lookup; every nibble value has a defined glyph.
  always_comb begin
    glyph = HEX_GLYPH[nibble];
  end

endmodule

// File: rtl/code_seg_scan.sv
// Time-multiplexed 7-segment scanner for the switch code-entry path.
// A loaded code waits in pending registers and is only promoted to the
// displayed (shadow) copy at a frame boundary, so a frame never tears.
module code_seg_scan
  import code_seg_scan_pkg::*;
#(
  parameter int Byte         = 4,
  parameter int CLK_DIV      = 50000,
  parameter int DEAD         = 500,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [4*Byte-1:0] Code,
  input  logic [2:0]        Code_Bit,
  input  logic              Code_Load,
  output logic              Load_Ack,
  output logic [7:0]        Seg,
  output logic [Byte-1:0]   An
);

  localparam int SLOT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIG_W  = (Byte > 1) ? $clog2(Byte) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_DEAD = SLOT_W'(DEAD);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(Byte - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]        CNT_MAX   = (Byte > 7) ? 3'd7 : 3'(Byte);
  localparam logic              POL       = (ACTIVE_LOW != 0);

  // Saturate the entered-digit count at the number of display digits.
  function automatic logic [2:0] sat_count(input logic [2:0] cnt);
    if (32'(cnt) > 32'(Byte)) return CNT_MAX;
    return cnt;
  endfunction

  logic [SLOT_W-1:0] slot_cnt;
  logic [DIG_W-1:0]  dig_idx;
  logic [FRM_W-1:0]  frm_cnt;
  logic              blink_ph;
  logic              slot_wrap;
  logic              frame_end;

  logic              pend;
  logic [4*Byte-1:0] pend_code;
  logic [2:0]        pend_cnt;
  logic [4*Byte-1:0] shd_code;
  logic [2:0]        shd_cnt;

  logic [3:0]        nib_p0;
  logic [7:0]        glyph_p0;
  dig_kind_e         kind_p0;
  logic [7:0]        seg_p0;
  logic [Byte-1:0]   an_p0;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_wrap && (dig_idx == DIG_LAST);

  // Slot, digit, frame and blink counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
      frm_cnt  <= '0;
      blink_ph <= 1'b0;
    end else begin
      if (slot_wrap) begin
        slot_cnt <= '0;
        dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_end) begin
        if (frm_cnt == FRM_LAST) begin
          frm_cnt  <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          frm_cnt <= frm_cnt + 1'b1;
        end
      end
    end
  end

  // Pending payload capture; newest strobe wins, validity lives in pend.
  always_ff @(posedge CLK) begin
    if (Code_Load) begin
      pend_code <= Code;
      pend_cnt  <= sat_count(Code_Bit);
    end
  end

  // Pending flag, frame-boundary promotion to shadow copy, and ack pulse.
  // A strobe in the frame-end cycle re-arms pend, so its data waits a frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend     <= 1'b0;
      shd_code <= '0;
      shd_cnt  <= '0;
      Load_Ack <= 1'b0;
    end else begin
      Load_Ack <= frame_end && pend;
      if (frame_end && pend) begin
        shd_code <= pend_code;
        shd_cnt  <= pend_cnt;
      end
      if (Code_Load) begin
        pend <= 1'b1;
      end else if (frame_end) begin
        pend <= 1'b0;
      end
    end
  end

  // Stage p0: select nibble and classify the digit under the scan.
  always_comb begin
    nib_p0 = '0;
    an_p0  = '0;
    for (int i = 0; i < Byte; i++) begin
      if (32'(dig_idx) == 32'(i)) begin
        nib_p0 = shd_code[4*i +: 4];
        an_p0[i] = (slot_cnt >= SLOT_DEAD);
      end
    end
    if (32'(dig_idx) < 32'(shd_cnt)) begin
      kind_p0 = DIG_GLYPH;
    end else if ((dig_idx == DIG_W'(shd_cnt)) && (32'(shd_cnt) < 32'(Byte)) && !blink_ph) begin
      kind_p0 = DIG_CURSOR;
    end else begin
      kind_p0 = DIG_BLANK;
    end
  end

  seg7_hex_decode u_dec (
    .nibble (nib_p0),
    .glyph  (glyph_p0)
  );

  // Glyph/cursor/blank selection for the scanned digit.
  always_comb begin
    seg_p0 = SEG_BLANK;
    case (kind_p0)
      DIG_GLYPH:  seg_p0 = glyph_p0;
      DIG_CURSOR: seg_p0 = SEG_CURSOR;
      default:    seg_p0 = SEG_BLANK;
    endcase
  end

  // Stage p1: registered outputs, board polarity applied only here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      An  <= {Byte{POL}};
      Seg <= {8{POL}};
    end else begin
      An  <= an_p0 ^ {Byte{POL}};
      Seg <= seg_p0 ^ {8{POL}};
    end
  end

endmodule

// File: tb/tb_code_seg_scan.sv
// Directed bench for code_seg_scan with a short scan: 8 cycles per slot,
// 2 dead cycles, 2 frames per blink half-period, active-low outputs.
// cyc counts rising edges since the last reset edge; outputs seen after
// edge cyc reflect counter state cyc-1 (slot=(cyc-1)%8, digit=((cyc-1)/8)%4).
module tb_code_seg_scan;

  localparam int BYTE = 4;
  localparam int CDIV = 8;
  localparam int DT   = 2;
  localparam int BLF  = 2;

  // Expected active-low glyphs.
  localparam logic [7:0] G_1 = 8'hF9;
  localparam logic [7:0] G_2 = 8'hA4;
  localparam logic [7:0] G_3 = 8'hB0;
  localparam logic [7:0] G_5 = 8'h92;
  localparam logic [7:0] G_7 = 8'hF8;
  localparam logic [7:0] G_A = 8'h88;
  localparam logic [7:0] G_F = 8'h8E;
  localparam logic [7:0] G_CUR = 8'hF7;
  localparam logic [7:0] G_OFF = 8'hFF;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [4*BYTE-1:0] Code;
  logic [2:0]        Code_Bit;
  logic              Code_Load;
  logic              Load_Ack;
  logic [7:0]        Seg;
  logic [BYTE-1:0]   An;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  code_seg_scan #(
    .Byte(BYTE), .CLK_DIV(CDIV), .DEAD(DT), .BLINK_FRAMES(BLF), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Code(Code), .Code_Bit(Code_Bit),
    .Code_Load(Code_Load), .Load_Ack(Load_Ack), .Seg(Seg), .An(An)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    Code_Load = 1'b0;
    repeat (n) tick();
    RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    RESET = 1'b1;
    Code = 16'h12A7;
    Code_Bit = 3'd4;
    Code_Load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (An !== 4'hF) begin n_err++; $display("FAIL reset_an k=%0d got=%h exp=f", k, An); end
      n_cmp++; if (Seg !== 8'hFF) begin n_err++; $display("FAIL reset_seg k=%0d got=%h exp=ff", k, Seg); end
      n_cmp++; if (Load_Ack !== 1'b0) begin n_err++; $display("FAIL reset_ack k=%0d got=%b exp=0", k, Load_Ack); end
    end
    Code_Load = 1'b0;
    RESET = 1'b0;
    cyc = 0;
    // First slot after release: empty display, cursor on digit 0.
    while (cyc < 8) begin
      tick();
      ea = 4'hF;
      if ((cyc - 1) % CDIV >= DT) ea[0] = 1'b0;
      n_cmp++; if (An !== ea) begin n_err++; $display("FAIL post_reset_an cyc=%0d got=%h exp=%h", cyc, An, ea); end
      n_cmp++; if (Seg !== G_CUR) begin n_err++; $display("FAIL post_reset_seg cyc=%0d got=%h exp=%h", cyc, Seg, G_CUR); end
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] g [4];
    logic [3:0] ea;
    int s, d, acks;
    g = '{G_7, G_A, G_2, G_1};
    acks = 0;
    do_reset(2);
    Code = 16'h12A7; Code_Bit = 3'd4; Code_Load = 1'b1;
    while (cyc < 64) begin
      tick();
      Code_Load = 1'b0;
      if (Load_Ack === 1'b1) acks++;
      n_cmp++; if (Load_Ack !== (cyc == 32)) begin n_err++; $display("FAIL basic_ack cyc=%0d got=%b", cyc, Load_Ack); end
      if (cyc >= 33) begin
        s = (cyc - 1) % CDIV; d = ((cyc - 1) / CDIV) % BYTE;
        ea = 4'hF; if (s >= DT) ea[d] = 1'b0;
        n_cmp++; if (An !== ea) begin n_err++; $display("FAIL basic_an cyc=%0d got=%h exp=%h", cyc, An, ea); end
        n_cmp++; if (Seg !== g[d]) begin n_err++; $display("FAIL basic_seg cyc=%0d got=%h exp=%h", cyc, Seg, g[d]); end
      end
    end
    n_cmp++; if (acks != 1) begin n_err++; $display("FAIL basic_ack_count got=%0d exp=1", acks); end
  endtask

  task automatic test_partial_cursor();
    logic [7:0] es;
    logic [3:0] ea;
    int s, d, ph;
    do_reset(2);
    Code = 16'h0035; Code_Bit = 3'd2; Code_Load = 1'b1;
    while (cyc < 160) begin
      tick();
      Code_Load = 1'b0;
      n_cmp++; if (Load_Ack !== (cyc == 32)) begin n_err++; $display("FAIL partial_ack cyc=%0d got=%b", cyc, Load_Ack); end
      if (cyc >= 33) begin
        s = (cyc - 1) % CDIV; d = ((cyc - 1) / CDIV) % BYTE;
        ph = (((cyc - 1) / 32) / BLF) % 2;
        case (d)
          0: es = G_5;
          1: es = G_3;
          2: es = (ph == 0) ? G_CUR : G_OFF;
          default: es = G_OFF;
        endcase
        ea = 4'hF; if (s >= DT) ea[d] = 1'b0;
        n_cmp++; if (An !== ea) begin n_err++; $display("FAIL partial_an cyc=%0d got=%h exp=%h", cyc, An, ea); end
        n_cmp++; if (Seg !== es) begin n_err++; $display("FAIL partial_seg cyc=%0d got=%h exp=%h", cyc, Seg, es); end
      end
    end
  endtask

  task automatic test_clamp_overwrite();
    int acks, d;
    acks = 0;
    do_reset(2);
    Code = 16'h1234; Code_Bit = 3'd7; Code_Load = 1'b1;
    while (cyc < 96) begin
      tick();
      Code_Load = (cyc == 3);
      if (cyc == 3) Code = 16'hFFFF;
      if (Load_Ack === 1'b1) acks++;
      n_cmp++; if (Load_Ack !== (cyc == 32)) begin n_err++; $display("FAIL clamp_ack cyc=%0d got=%b", cyc, Load_Ack); end
      if (cyc >= 33) begin
        d = ((cyc - 1) / CDIV) % BYTE;
        n_cmp++; if (Seg !== G_F) begin n_err++; $display("FAIL clamp_seg cyc=%0d digit=%0d got=%h exp=%h", cyc, d, Seg, G_F); end
      end
    end
    n_cmp++; if (acks != 1) begin n_err++; $display("FAIL clamp_ack_count got=%0d exp=1", acks); end
  endtask

  task automatic test_frame_end_load();
    logic [7:0] old_g [4];
    logic [7:0] es;
    int d, ph;
    old_g = '{G_7, G_A, G_2, G_1};
    do_reset(2);
    Code = 16'h12A7; Code_Bit = 3'd4; Code_Load = 1'b1;
    while (cyc < 160) begin
      tick();
      Code_Load = (cyc == 63);
      if (cyc == 63) begin Code = 16'h0035; Code_Bit = 3'd2; end
      n_cmp++; if (Load_Ack !== (cyc == 32 || cyc == 96)) begin n_err++; $display("FAIL fend_ack cyc=%0d got=%b", cyc, Load_Ack); end
      if (cyc >= 33) begin
        d = ((cyc - 1) / CDIV) % BYTE;
        ph = (((cyc - 1) / 32) / BLF) % 2;
        if (cyc <= 96) es = old_g[d];
        else begin
          case (d)
            0: es = G_5;
            1: es = G_3;
            2: es = (ph == 0) ? G_CUR : G_OFF;
            default: es = G_OFF;
          endcase
        end
        n_cmp++; if (Seg !== es) begin n_err++; $display("FAIL fend_seg cyc=%0d got=%h exp=%h", cyc, Seg, es); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ea;
    logic [7:0] es;
    int s, d;
    do_reset(2);
    Code = 16'h12A7; Code_Bit = 3'd4; Code_Load = 1'b1;
    while (cyc < 50) begin
      tick();
      Code_Load = (cyc == 40);
      if (cyc == 40) begin Code = 16'h0035; Code_Bit = 3'd2; end
    end
    // Scan is on digit 2 with a load pending.
    RESET = 1'b1;
    tick();
    n_cmp++; if (An !== 4'hF) begin n_err++; $display("FAIL mid_reset_an got=%h exp=f", An); end
    n_cmp++; if (Seg !== 8'hFF) begin n_err++; $display("FAIL mid_reset_seg got=%h exp=ff", Seg); end
    n_cmp++; if (Load_Ack !== 1'b0) begin n_err++; $display("FAIL mid_reset_ack got=%b exp=0", Load_Ack); end
    RESET = 1'b0;
    cyc = 0;
    while (cyc < 64) begin
      tick();
      s = (cyc - 1) % CDIV; d = ((cyc - 1) / CDIV) % BYTE;
      ea = 4'hF; if (s >= DT) ea[d] = 1'b0;
      es = (d == 0) ? G_CUR : G_OFF;
      n_cmp++; if (Load_Ack !== 1'b0) begin n_err++; $display("FAIL mid_ack cyc=%0d got=%b exp=0", cyc, Load_Ack); end
      n_cmp++; if (An !== ea) begin n_err++; $display("FAIL mid_an cyc=%0d got=%h exp=%h", cyc, An, ea); end
      n_cmp++; if (Seg !== es) begin n_err++; $display("FAIL mid_seg cyc=%0d got=%h exp=%h", cyc, Seg, es); end
    end
  endtask

  initial begin
    RESET = 1'b0;
    Code = '0;
    Code_Bit = '0;
    Code_Load = 1'b0;
    test_reset();
    test_basic_load();
    test_partial_cursor();
    test_clamp_overwrite();
    test_frame_end_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
